fb_access_arbiter: RTL and testbench

Arbitrates the single-port frame buffer among the VGA scanout reader and two game-logic writers (sprite engine, playfield updater). Scanout always owns the port during the visible window derived from the horizontal/vertical line counters. Writers share the remaining cycles round-robin through a REQ/GNT handshake. Also emits a one-cycle vertical-blank-start tick so game logic can schedule frame updates.

---
 rtl/fb_access_arbiter.sv | 97 +++++++++
 tb/tb_fb_access_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fb_access_arbiter.sv
// Frame buffer port arbiter: scanout owns the port in the visible window,
// two writers share the remaining cycles round-robin via REQ/GNT.
module fb_access_arbiter #(
  parameter int H_ACT_START = 144,
  parameter int H_ACT_END   = 783,
  parameter int V_ACT_START = 35,
  parameter int V_ACT_END   = 514,
  parameter int ADDR_W      = 19,
  parameter int DATA_W      = 8
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [9:0]        H,
  input  logic [9:0]        V,
  input  logic [ADDR_W-1:0] DISP_ADDR,
  input  logic [1:0]        REQ,
  input  logic [ADDR_W-1:0] ADDR0,
  input  logic [ADDR_W-1:0] ADDR1,
  input  logic [DATA_W-1:0] DATA0,
  input  logic [DATA_W-1:0] DATA1,
  input  logic              VBLANK_ONLY,
  output logic [1:0]        GNT,
  output logic [ADDR_W-1:0] FB_ADDR,
  output logic [DATA_W-1:0] FB_WDATA,
  output logic              FB_WE,
  output logic              FB_DISP,
  output logic              VB_TICK
);

  // The horizontal window is shifted one column early so the registered
  // FB_DISP lines up with the pixel actually being shown.
  localparam logic [9:0] DW_H_LO = 10'(H_ACT_START - 1);
  localparam logic [9:0] DW_H_HI = 10'(H_ACT_END - 1);
  localparam logic [9:0] ACT_V_LO = 10'(V_ACT_START);
  localparam logic [9:0] ACT_V_HI = 10'(V_ACT_END);
  localparam logic [9:0] VB_V     = 10'(V_ACT_END + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DISP = 2'd1,
    WR   = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [1:0]          gnt_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic [DATA_W-1:0]   wdata_nxt;
  logic                last, last_nxt;
  logic                v_active, disp_win, wr_win, pick1, vb_nxt;

  assign v_active = (V >= ACT_V_LO) && (V <= ACT_V_HI);
  assign disp_win = v_active && (H >= DW_H_LO) && (H <= DW_H_HI);
  assign wr_win   = !disp_win && (!VBLANK_ONLY || !v_active);
  // Writer 1 wins when it is the only requester, or on a tie when writer 0 went last.
  assign pick1    = REQ[1] && (!REQ[0] || !last);
  assign vb_nxt   = (V == VB_V) && (H == 10'd0);

  always_comb begin
    state_nxt = IDLE;
    gnt_nxt   = 2'b00;
    addr_nxt  = FB_ADDR;
    wdata_nxt = FB_WDATA;
    last_nxt  = last;
    if (disp_win) begin
      state_nxt = DISP;
      addr_nxt  = DISP_ADDR;
    end else if (wr_win && (REQ != 2'b00)) begin
      state_nxt = WR;
      gnt_nxt   = pick1 ? 2'b10 : 2'b01;
      addr_nxt  = pick1 ? ADDR1 : ADDR0;
      wdata_nxt = pick1 ? DATA1 : DATA0;
      last_nxt  = pick1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state    <= IDLE;
      GNT      <= 2'b00;
      FB_ADDR  <= '0;
      FB_WDATA <= '0;
      last     <= 1'b1;
      VB_TICK  <= 1'b0;
    end else begin
      state    <= state_nxt;
      GNT      <= gnt_nxt;
      FB_ADDR  <= addr_nxt;
      FB_WDATA <= wdata_nxt;
      last     <= last_nxt;
      VB_TICK  <= vb_nxt;
    end
  end

  assign FB_WE   = (state == WR);
  assign FB_DISP = (state == DISP);

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Self-checking bench for fb_access_arbiter: directed scenarios followed by
// randomized traffic, all checked against a transaction-level reference model.
module tb_fb_access_arbiter;

  localparam int AW = 19;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RSTN = 1'b0;
  logic [9:0]    H = '0;
  logic [9:0]    V = '0;
  logic [AW-1:0] DISP_ADDR = '0;
  logic [1:0]    REQ = '0;
  logic [AW-1:0] ADDR0 = '0, ADDR1 = '0;
  logic [DW-1:0] DATA0 = '0, DATA1 = '0;
  logic          VBLANK_ONLY = 1'b0;
  logic [1:0]    GNT;
  logic [AW-1:0] FB_ADDR;
  logic [DW-1:0] FB_WDATA;
  logic          FB_WE, FB_DISP, VB_TICK;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: which writer is favoured on the next tie,
  // and which writers the bench requesters still have a pending write for.
  int         favoured = 0;
  logic [1:0] pend = 2'b00;

  always #5 CLK = ~CLK;

  fb_access_arbiter dut (
    .CLK(CLK), .RSTN(RSTN), .H(H), .V(V), .DISP_ADDR(DISP_ADDR), .REQ(REQ),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .DATA0(DATA0), .DATA1(DATA1),
    .VBLANK_ONLY(VBLANK_ONLY), .GNT(GNT), .FB_ADDR(FB_ADDR),
    .FB_WDATA(FB_WDATA), .FB_WE(FB_WE), .FB_DISP(FB_DISP), .VB_TICK(VB_TICK)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of inputs, predicts the outputs from the rules of the
  // port ownership, waits for the edge and compares.
  task automatic applyStimulus(input logic rstn, input int h, input int v,
                               input logic [1:0] req, input logic vbo);
    int            pix, winner;
    logic          inAct, disp, canWrite;
    logic [1:0]    eGnt;
    logic [AW-1:0] eAddr;
    logic [DW-1:0] eData;
    logic          eVb;
    RSTN = rstn; H = h[9:0]; V = v[9:0]; REQ = req; VBLANK_ONLY = vbo;
    DISP_ADDR = AW'($urandom);
    if (!pend[0]) begin ADDR0 = AW'($urandom); DATA0 = DW'($urandom); end
    if (!pend[1]) begin ADDR1 = AW'($urandom); DATA1 = DW'($urandom); end
    pend = req;

    pix      = (h % 1024) + 1;
    inAct    = (v % 1024) >= 35 && (v % 1024) <= 514;
    disp     = inAct && pix >= 144 && pix <= 783;
    canWrite = !disp && (!vbo || !inAct);
    winner   = (req == 2'b11) ? favoured : ((req == 2'b10) ? 1 : 0);
    eGnt     = (canWrite && req != 2'b00) ? 2'(1 << winner) : 2'b00;
    eAddr    = disp ? DISP_ADDR : (winner == 1 ? ADDR1 : ADDR0);
    eData    = (winner == 1) ? DATA1 : DATA0;
    eVb      = ((v % 1024) == 515) && ((h % 1024) == 0);
    if (!rstn) begin
      eGnt = 2'b00; disp = 1'b0; eVb = 1'b0; eAddr = '0; eData = '0;
    end

    @(posedge CLK);
    #1;
    checkOutput("GNT", 32'(GNT), 32'(eGnt));
    checkOutput("FB_WE", 32'(FB_WE), 32'(eGnt != 2'b00));
    checkOutput("FB_DISP", 32'(FB_DISP), 32'(disp));
    checkOutput("VB_TICK", 32'(VB_TICK), 32'(eVb));
    if (disp || eGnt != 2'b00 || !rstn)
      checkOutput("FB_ADDR", 32'(FB_ADDR), 32'(eAddr));
    if (eGnt != 2'b00 || !rstn)
      checkOutput("FB_WDATA", 32'(FB_WDATA), 32'(eData));

    if (!rstn) favoured = 0;
    else if (eGnt != 2'b00) favoured = 1 - winner;
    pend = pend & ~GNT;
  endtask

  initial begin
    int         dispCount, earlyGnt, hh, vv;
    logic [1:0] rr [6];
    logic [1:0] rq;
    logic       vbo;

    // Reset with both writers requesting, then first grant goes to writer 0.
    applyStimulus(1'b0, 10, 520, 2'b11, 1'b0);
    applyStimulus(1'b0, 10, 520, 2'b11, 1'b0);
    checkOutput("reset FB_ADDR", 32'(FB_ADDR), 32'd0);
    checkOutput("reset GNT", 32'(GNT), 32'd0);
    applyStimulus(1'b1, 10, 520, 2'b11, 1'b0);
    checkOutput("first tie GNT", 32'(GNT), 32'b01);

    // Display ownership sweep with writer 0 streaming; also the preemption edge.
    dispCount = 0;
    for (int h = 140; h <= 790; h++) begin
      applyStimulus(1'b1, h, 100, 2'b01, 1'b0);
      if (FB_DISP) dispCount++;
      if (h == 142) checkOutput("pre-window GNT", 32'(GNT), 32'b01);
      if (h == 143) begin
        checkOutput("window open DISP", 32'(FB_DISP), 32'd1);
        checkOutput("window open WE", 32'(FB_WE), 32'd0);
      end
      if (h == 783) checkOutput("post-window GNT", 32'(GNT), 32'b01);
    end
    checkOutput("disp cycles", 32'(dispCount), 32'd640);

    // Round-robin from reset in vertical blank.
    applyStimulus(1'b0, 0, 520, 2'b00, 1'b0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 10 + i, 520, 2'b11, 1'b0);
      rr[i] = GNT;
    end
    for (int i = 0; i < 6; i++)
      checkOutput($sformatf("rr[%0d]", i), 32'(rr[i]), (i % 2 == 0) ? 32'b01 : 32'b10);

    // VBLANK_ONLY keeps writer 1 waiting through the active lines.
    earlyGnt = 0;
    applyStimulus(1'b1, 10, 200, 2'b10, 1'b1);
    if (GNT != 2'b00) earlyGnt++;
    for (int v = 505; v <= 514; v++) begin
      applyStimulus(1'b1, 10, v, 2'b10, 1'b1);
      if (GNT != 2'b00) earlyGnt++;
    end
    checkOutput("vblank-only early grants", 32'(earlyGnt), 32'd0);
    applyStimulus(1'b1, 10, 515, 2'b10, 1'b1);
    checkOutput("vblank-only GNT", 32'(GNT), 32'b10);

    // Vertical blank tick, then reset in the middle of a streaming write.
    applyStimulus(1'b1, 0, 514, 2'b00, 1'b0);
    applyStimulus(1'b1, 0, 515, 2'b00, 1'b0);
    checkOutput("VB_TICK pulse", 32'(VB_TICK), 32'd1);
    applyStimulus(1'b1, 1, 515, 2'b00, 1'b0);
    checkOutput("VB_TICK single", 32'(VB_TICK), 32'd0);
    applyStimulus(1'b1, 20, 520, 2'b11, 1'b0);
    applyStimulus(1'b1, 21, 520, 2'b11, 1'b0);
    applyStimulus(1'b0, 22, 520, 2'b11, 1'b0);
    checkOutput("mid-write reset WE", 32'(FB_WE), 32'd0);
    checkOutput("mid-write reset GNT", 32'(GNT), 32'd0);

    // Randomized traffic biased toward window boundaries.
    vbo = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0: hh = $urandom_range(0, 1023);
        1: hh = $urandom_range(140, 146);
        2: hh = $urandom_range(780, 786);
        default: hh = $urandom_range(0, 2);
      endcase
      case ($urandom_range(0, 3))
        0: vv = $urandom_range(0, 1023);
        1: vv = $urandom_range(33, 37);
        2: vv = $urandom_range(512, 517);
        default: vv = ($urandom_range(0, 1) == 0) ? 100 : 520;
      endcase
      if ($urandom_range(0, 19) == 0) vbo = ~vbo;
      rq = pend | 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(0, 99) != 0, hh, vv, rq, vbo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
